// File: rtl/dkong_wav_fetch.sv
// Wave ROM byte fetcher: follows the sequencer address, reads the byte over req/ack,
// converts it to signed 16-bit PCM with an optional one-pole low-pass, and silences on idle.
module dkong_wav_fetch #(
    parameter int unsigned CLOCK_RATE  = 24000000,
    parameter int unsigned IDLE_CYCLES = 8708,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned FILT_SHIFT  = 0,
    parameter logic [18:0] RST_AB      = 19'h10000
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic [18:0] I_ROM_AB,
    output logic        O_REQ,
    output logic [18:0] O_ADDR,
    input  logic        I_ACK,
    input  logic [7:0]  I_DATA,
    output logic [15:0] O_SAMPLE,
    output logic        O_SAMPLE_VLD,
    output logic        O_ACTIVE,
    output logic        O_ERR
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

    if (IDLE_CYCLES == 0 || CLOCK_RATE == 0) begin : g_param_check
        $error("dkong_wav_fetch: IDLE_CYCLES and CLOCK_RATE must be non-zero");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONV} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [18:0]        last_ab;
    logic               pending;
    logic [IW-1:0]      idle_cnt;
    logic [7:0]         to_cnt;
    logic [7:0]         data_q;
    logic signed [15:0] filt;

    logic               chg;
    logic               idle_hit;
    logic               idle_done;
    logic               to_hit;
    logic               start_fetch;
    logic               take_ack;
    logic               take_to;
    logic               do_conv;

    logic signed [15:0] x;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [15:0] filt_nxt;
    logic signed [15:0] sample_nxt;

    assign chg       = (I_ROM_AB != last_ab);
    assign idle_done = (idle_cnt == IW'(IDLE_CYCLES));
    // chg beats the idle threshold, so a change landing on that cycle never silences
    assign idle_hit  = !chg && (idle_cnt == IW'(IDLE_CYCLES - 1));
    assign to_hit    = (to_cnt == 8'(ACK_TIMEOUT));

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pending) state_nxt = S_WAIT;
            S_WAIT: begin
                if (I_ACK)       state_nxt = S_CONV;
                else if (to_hit) state_nxt = S_IDLE;
            end
            S_CONV:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_fetch = (state == S_IDLE) && pending;
        take_ack    = (state == S_WAIT) && I_ACK;
        take_to     = (state == S_WAIT) && !I_ACK && to_hit;
        do_conv     = (state == S_CONV);
    end

    // Offset-binary to two's complement: flip the MSB and scale by 256
    always_comb begin
        x          = {~data_q[7], data_q[6:0], 8'h00};
        diff       = {x[15], x} - {filt[15], filt};
        step       = diff >>> FILT_SHIFT;
        filt_nxt   = filt + step[15:0];
        sample_nxt = (FILT_SHIFT == 0) ? x : filt_nxt;
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            last_ab      <= RST_AB;
            pending      <= 1'b0;
            idle_cnt     <= '0;
            to_cnt       <= '0;
            data_q       <= '0;
            filt         <= '0;
            O_REQ        <= 1'b0;
            O_ADDR       <= '0;
            O_SAMPLE     <= '0;
            O_SAMPLE_VLD <= 1'b0;
            O_ACTIVE     <= 1'b0;
            O_ERR        <= 1'b0;
        end else begin
            O_SAMPLE_VLD <= 1'b0;

            if (chg) begin
                last_ab  <= I_ROM_AB;
                pending  <= 1'b1;
                idle_cnt <= '0;
            end else begin
                if (!idle_done) idle_cnt <= idle_cnt + 1'b1;
                if (start_fetch) pending <= 1'b0;
            end

            if (start_fetch) begin
                O_ADDR <= last_ab;
                O_REQ  <= 1'b1;
                to_cnt <= '0;
            end

            if (take_ack) begin
                O_REQ  <= 1'b0;
                data_q <= I_DATA;
            end else if (take_to) begin
                O_REQ <= 1'b0;
                O_ERR <= 1'b1;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (idle_hit) begin
                O_SAMPLE     <= '0;
                filt         <= '0;
                O_ACTIVE     <= 1'b0;
                O_SAMPLE_VLD <= O_ACTIVE;
            end else if (do_conv && !idle_done) begin
                O_SAMPLE     <= sample_nxt;
                filt         <= filt_nxt;
                O_SAMPLE_VLD <= 1'b1;
                O_ACTIVE     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dkong_wav_fetch.sv
// Scoreboard bench for dkong_wav_fetch: a bypass instance and a FILT_SHIFT=2 instance share
// one ROM responder; expected PCM values come from integer arithmetic on the acked byte.
module tb_dkong_wav_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] rom_ab;
    logic        ack;
    logic [7:0]  data;

    logic        req0, req1;
    logic [18:0] addr0, addr1;
    logic [15:0] smp0, smp1;
    logic        vld0, vld1, act0, act1, err0, err1;

    always #5 clk = ~clk;

    dkong_wav_fetch #(.IDLE_CYCLES(600), .ACK_TIMEOUT(255), .FILT_SHIFT(0)) dut_byp (
        .I_CLK(clk), .I_RSTn(rst_n), .I_ROM_AB(rom_ab),
        .O_REQ(req0), .O_ADDR(addr0), .I_ACK(ack), .I_DATA(data),
        .O_SAMPLE(smp0), .O_SAMPLE_VLD(vld0), .O_ACTIVE(act0), .O_ERR(err0)
    );

    dkong_wav_fetch #(.IDLE_CYCLES(600), .ACK_TIMEOUT(255), .FILT_SHIFT(2)) dut_flt (
        .I_CLK(clk), .I_RSTn(rst_n), .I_ROM_AB(rom_ab),
        .O_REQ(req1), .O_ADDR(addr1), .I_ACK(ack), .I_DATA(data),
        .O_SAMPLE(smp1), .O_SAMPLE_VLD(vld1), .O_ACTIVE(act1), .O_ERR(err1)
    );

    typedef struct packed {
        logic [15:0] byp;
        logic [15:0] flt;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [18:0] req_log[$];
    logic [7:0]  rom [logic [18:0]];
    int          filt_m    = 0;
    int          ack_delay = 0;
    bit          no_ack    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push_sample(input logic [7:0] d);
        int xv;
        xv     = (int'(d) - 128) * 256;
        filt_m = filt_m + ((xv - filt_m) >>> 2);
        sb.push_back('{byp: 16'(xv), flt: 16'(filt_m)});
    endtask

    task automatic push_silence();
        filt_m = 0;
        sb.push_back('{byp: 16'h0000, flt: 16'h0000});
    endtask

    // ROM port: acks ack_delay cycles after O_REQ is seen, data from the bench ROM image
    initial begin
        int w;
        w    = 0;
        ack  = 1'b0;
        data = 8'h00;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (rst_n && req0 && !no_ack) begin
                if (w >= ack_delay) begin
                    ack  = 1'b1;
                    data = rom.exists(addr0) ? rom[addr0] : 8'h00;
                    push_sample(data);
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    initial begin
        logic req_prev;
        exp_t e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req0 && !req_prev) req_log.push_back(addr0);
                if (vld0 || vld1) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_vld: got vld %b/%b sample %h/%h expected no pulse",
                                 vld0, vld1, smp0, smp1);
                    end else begin
                        e = sb.pop_front();
                        check("vld_byp", {31'd0, vld0}, 32'd1);
                        check("vld_flt", {31'd0, vld1}, 32'd1);
                        check("sample_byp", {16'd0, smp0}, {16'd0, e.byp});
                        check("sample_flt", {16'd0, smp1}, {16'd0, e.flt});
                    end
                end
            end
            req_prev = rst_n && req0;
        end
    end

    initial begin
        #800000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic [18:0] a, input logic [7:0] d);
        rom[a] = d;
        rom_ab = a;
    endtask

    task automatic wait_vld(input string name, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!vld0 && lat < budget);
        check({name, "_vld"}, {31'd0, vld0}, 32'd1);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (!req0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req"}, {31'd0, req0}, 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        int quiet;
        n     = 0;
        quiet = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (sb.size() == 0 && !req0 && !vld0) quiet++;
            else quiet = 0;
        end
        check({name, "_drain"}, {31'd0, quiet >= 4}, 32'd1);
    endtask

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
        logic [15:0] s;
    } dir_t;

    initial begin
        dir_t        dir[3];
        int          lat;
        int          viol;
        int          n;
        logic [15:0] prev;
        logic [18:0] a;

        dir[0] = '{19'h11000, 8'hFF, 16'h7F00};
        dir[1] = '{19'h11004, 8'h80, 16'h0000};
        dir[2] = '{19'h11005, 8'h00, 16'h8000};

        rst_n  = 1'b0;
        rom_ab = 19'h10000;
        tick(3);
        check("rst_req",    {31'd0, req0},  32'd0);
        check("rst_addr",   {13'd0, addr0}, 32'd0);
        check("rst_sample", {16'd0, smp0},  32'd0);
        check("rst_vld",    {31'd0, vld0},  32'd0);
        check("rst_active", {31'd0, act0},  32'd0);
        check("rst_err",    {31'd0, err0},  32'd0);

        // Reset address held: no fetch, no sound, and the idle threshold passes silently
        rst_n = 1'b1;
        viol  = 0;
        repeat (2000) begin
            @(negedge clk);
            if (req0 || smp0 != 16'h0000 || act0 || act1) viol++;
        end
        check("hold_quiet", viol, 32'd0);

        // Ack in the first WAIT cycle: change registered at edge N, pulse after edge N+3
        ack_delay = 0;
        foreach (dir[i]) begin
            req_log.delete();
            set_ab(dir[i].a, dir[i].d);
            wait_vld("direct", 10, lat);
            check("direct_latency", lat, 32'd4);
            check("direct_sample", {16'd0, smp0}, {16'd0, dir[i].s});
            check("direct_nreq", req_log.size(), 32'd1);
            if (req_log.size() > 0) check("direct_addr", {13'd0, req_log[0]}, {13'd0, dir[i].a});
            check("direct_active", {31'd0, act0}, 32'd1);
            tick(2);
        end

        // Two changes during WAIT: only the newest address gets the follow-up fetch
        ack_delay = 5;
        req_log.delete();
        set_ab(19'h12000, 8'h3A);
        wait_req("coalesce", 5);
        tick(1);
        set_ab(19'h12001, 8'h91);
        tick(1);
        set_ab(19'h12002, 8'hE7);
        drain("coalesce", 100);
        check("coalesce_nreq", req_log.size(), 32'd2);
        if (req_log.size() == 2) begin
            check("coalesce_first", {13'd0, req_log[0]}, {13'd0, 19'h12000});
            check("coalesce_last",  {13'd0, req_log[1]}, {13'd0, 19'h12002});
        end

        // Idle silencing after a 0xC0 sample
        ack_delay = 0;
        set_ab(19'h13000, 8'hC0);
        wait_vld("idle_pre", 10, lat);
        check("idle_pre_sample", {16'd0, smp0}, 32'h4000);
        push_silence();
        tick(1);
        wait_vld("idle_silence", 700, lat);
        check("idle_sample_byp", {16'd0, smp0}, 32'd0);
        check("idle_sample_flt", {16'd0, smp1}, 32'd0);
        check("idle_active_byp", {31'd0, act0}, 32'd0);
        check("idle_active_flt", {31'd0, act1}, 32'd0);
        tick(100);
        check("idle_stays_off", {31'd0, act0}, 32'd0);
        set_ab(19'h13001, 8'h80);
        wait_vld("idle_resume", 10, lat);
        check("idle_resume_active", {31'd0, act0}, 32'd1);
        tick(2);

        // Ack never comes: request held 256 cycles, sticky error, sample untouched
        no_ack = 1'b1;
        prev   = smp0;
        set_ab(19'h14000, 8'h55);
        wait_req("timeout", 5);
        n = 0;
        while (req0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", n, 32'd256);
        check("timeout_err_byp", {31'd0, err0}, 32'd1);
        check("timeout_err_flt", {31'd0, err1}, 32'd1);
        check("timeout_sample", {16'd0, smp0}, {16'd0, prev});
        no_ack = 1'b0;
        set_ab(19'h14001, 8'h80);
        wait_vld("timeout_recover", 10, lat);
        check("timeout_err_sticky", {31'd0, err0}, 32'd1);
        tick(2);

        // Filter step response from 0 toward 0x7F00
        prev = 16'h0000;
        viol = 0;
        for (int i = 0; i < 12; i++) begin
            set_ab(19'h15000 + 19'(i), 8'hFF);
            wait_vld("step", 10, lat);
            if (i == 0) check("step_first", {16'd0, smp1}, 32'h1FC0);
            if ($signed(smp1) < $signed(prev) || $signed(smp1) > $signed(16'h7F00)) viol++;
            prev = smp1;
            tick(2);
        end
        check("step_monotonic", viol, 32'd0);

        // Random addresses, bytes, ack delays and change spacing
        a = 19'h16000;
        for (int i = 0; i < 300; i++) begin
            ack_delay = int'($urandom_range(0, 4));
            a         = a + 19'($urandom_range(1, 5000));
            set_ab(a, 8'($urandom));
            tick(int'($urandom_range(0, 8)));
        end
        drain("random", 200);
        check("random_sb_empty", sb.size(), 32'd0);

        // Reset in the middle of a fetch
        no_ack = 1'b1;
        set_ab(a + 19'd1, 8'h12);
        wait_req("midreset", 10);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("midreset_req",    {31'd0, req0}, 32'd0);
        check("midreset_sample", {16'd0, smp0}, 32'd0);
        check("midreset_active", {31'd0, act0}, 32'd0);
        check("midreset_err",    {31'd0, err0}, 32'd0);
        filt_m = 0;
        rst_n  = 1'b1;
        tick(5);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
